// File: rtl/pc_pkg.sv
// Shared defaults and next-PC source encoding for the fetch-stage PC unit.
package pc_pkg;

  localparam int          PC_ADDR_W       = 32;
  localparam int          PC_INCR         = 4;
  localparam logic [31:0] PC_RESET_VECTOR = 32'h0;
  localparam int          PC_RAS_DEPTH    = 4;

  typedef enum logic [1:0] {
    SRC_HOLD,
    SRC_RET,
    SRC_REDIRECT,
    SRC_SEQ
  } pc_src_e;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: push/pop/replace, registered empty/full, sticky over/underflow.
// State updates one edge after the request; a pop reads the top entry combinationally, never stalls.
module return_addr_stack #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_dat,
  output logic [ADDR_W-1:0] top_dat,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  top_q, top_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              empty_q, full_q, ovf_q, ovf_d, unf_q, unf_d;

  always_comb begin
    mem_d = mem_q;
    top_d = top_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (pop && push && !empty_q) begin
      // Tail return: the popped slot is immediately reused for the new link.
      mem_d[top_q] = push_dat;
    end else if (pop && !empty_q) begin
      top_d = top_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      if (pop) unf_d = 1'b1;
      if (push) begin
        // When full the pointer wraps onto the oldest entry and overwrites it.
        top_d        = top_q + PTR_W'(1);
        mem_d[top_d] = push_dat;
        if (full_q) ovf_d = 1'b1;
        else        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      top_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == CNT_MAX);
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign top_dat   = mem_q[top_q];
  assign empty     = empty_q;
  assign full      = full_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: priority mux (reset > stall > ret > redirect > seq) over a return stack.
// pc is registered (request at edge N visible after N); stall holds all state, no other backpressure.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W       = PC_ADDR_W,
  parameter int                INCR         = PC_INCR,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(PC_RESET_VECTOR),
  parameter int                RAS_DEPTH    = PC_RAS_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] link_addr,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_overflow,
  output logic              ras_underflow,
  output logic              misalign_err
);

  localparam logic [ADDR_W-1:0] INCR_V     = ADDR_W'(INCR);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INCR - 1);

  pc_src_e           src;
  logic [ADDR_W-1:0] pc_q, pc_d, ras_top;
  logic              misalign_q, misalign_d;
  logic              rst_seen_q, rst_seen_d;
  logic              ras_push, ras_pop;

  assign link_addr = pc_q + INCR_V;

  always_comb begin
    src = SRC_SEQ;
    if (stall)               src = SRC_HOLD;
    else if (ret)            src = ras_empty ? SRC_SEQ : SRC_RET;
    else if (redirect_valid) src = SRC_REDIRECT;
  end

  always_comb begin
    case (src)
      SRC_HOLD:     pc_d = pc_q;
      SRC_RET:      pc_d = ras_top;
      SRC_REDIRECT: pc_d = redirect_target & ~ALIGN_MASK;
      default:      pc_d = link_addr;
    endcase
    if (reset) pc_d = RESET_VECTOR;
  end

  // A link is pushed for call+redirect and for call+ret (tail return), never for a bare call.
  always_comb begin
    ras_push   = !stall && call && (ret || redirect_valid);
    ras_pop    = !stall && ret;
    misalign_d = (src == SRC_REDIRECT) && |(redirect_target & ALIGN_MASK);
    rst_seen_d = rst_seen_q | reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_VECTOR;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
    rst_seen_q <= rst_seen_d;
  end

  return_addr_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_dat  (link_addr),
    .top_dat   (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  assign pc           = pc_q;
  assign pc_next      = pc_d;
  assign pc_valid     = rst_seen_q & ~reset;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit; expected PCs are queued when stimulus is driven and popped after the edge.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid, call, ret;
  logic [31:0] redirect_target;
  logic [31:0] pc, pc_next, link_addr;
  logic        pc_valid, ras_empty, ras_full, ras_overflow, ras_underflow, misalign_err;

  int          n_run  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q [$];
  logic [31:0] link_q [$];
  logic [31:0] e;

  always #5 clk = ~clk;

  pc_unit #(
    .ADDR_W(32), .INCR(4), .RESET_VECTOR(32'h0), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .call(call), .ret(ret),
    .pc(pc), .pc_valid(pc_valid), .pc_next(pc_next), .link_addr(link_addr),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow), .misalign_err(misalign_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic rv, input logic [31:0] t, input logic c, input logic r);
    stall = s; redirect_valid = rv; redirect_target = t; call = c; ret = r;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 32'h0, 0, 0);
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h0);
      tick();
      e = exp_q.pop_front();
      n_run++; if (pc !== e) begin n_fail++; $display("FAIL reset_pc%0d got=%h exp=%h", i, pc, e); end
      n_run++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid%0d got=%b exp=0", i, pc_valid); end
    end
    n_run++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin n_fail++; $display("FAIL reset_ras empty=%b full=%b exp 1/0", ras_empty, ras_full); end
    n_run++; if ({ras_overflow, ras_underflow, misalign_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {ras_overflow, ras_underflow, misalign_err}); end
    reset = 1'b0;
    #1;
    n_run++; if (pc_valid !== 1'b1 || pc !== 32'h0) begin n_fail++; $display("FAIL post_reset valid=%b pc=%h exp 1/0", pc_valid, pc); end
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(32'(i * 4));
      tick();
      e = exp_q.pop_front();
      n_run++; if (pc !== e) begin n_fail++; $display("FAIL seq_pc%0d got=%h exp=%h", i, pc, e); end
    end
  endtask

  task automatic test_call_ret();
    drive(0, 1, 32'h100, 0, 0); exp_q.push_back(32'h100); tick();
    e = exp_q.pop_front();
    n_run++; if (pc !== e) begin n_fail++; $display("FAIL cr_setup got=%h exp=%h", pc, e); end
    drive(0, 1, 32'h200, 1, 0); exp_q.push_back(32'h200);
    #1;
    n_run++; if (link_addr !== 32'h104 || pc_next !== 32'h200) begin n_fail++; $display("FAIL cr_comb link=%h next=%h exp 104/200", link_addr, pc_next); end
    tick();
    e = exp_q.pop_front();
    n_run++; if (pc !== e || ras_empty !== 1'b0) begin n_fail++; $display("FAIL cr_call pc=%h empty=%b exp %h/0", pc, ras_empty, e); end
    drive(0, 0, 32'h0, 0, 1); exp_q.push_back(32'h104); tick();
    e = exp_q.pop_front();
    n_run++; if (pc !== e || ras_empty !== 1'b1) begin n_fail++; $display("FAIL cr_ret pc=%h empty=%b exp %h/1", pc, ras_empty, e); end
  endtask

  task automatic test_nested();
    logic [31:0] tg [5];
    logic [31:0] cur;
    tg = '{32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h5000};
    do_reset();
    cur = 32'h0;
    link_q.delete();
    for (int i = 0; i < 5; i++) begin
      link_q.push_back(cur + 32'h4);
      if (link_q.size() > 4) void'(link_q.pop_front());
      drive(0, 1, tg[i], 1, 0); exp_q.push_back(tg[i]); tick();
      e = exp_q.pop_front();
      n_run++; if (pc !== e) begin n_fail++; $display("FAIL nest_call%0d got=%h exp=%h", i, pc, e); end
      if (i == 3) begin
        n_run++; if (ras_full !== 1'b1 || ras_overflow !== 1'b0) begin n_fail++; $display("FAIL nest_full full=%b ovf=%b exp 1/0", ras_full, ras_overflow); end
      end
      cur = tg[i];
    end
    n_run++; if (ras_overflow !== 1'b1 || ras_full !== 1'b1) begin n_fail++; $display("FAIL nest_ovf ovf=%b full=%b exp 1/1", ras_overflow, ras_full); end
    for (int i = 0; i < 4; i++) begin
      cur = link_q.pop_back();
      drive(0, 0, 32'h0, 0, 1); exp_q.push_back(cur); tick();
      e = exp_q.pop_front();
      n_run++; if (pc !== e) begin n_fail++; $display("FAIL nest_ret%0d got=%h exp=%h", i, pc, e); end
    end
    n_run++; if (ras_empty !== 1'b1 || ras_underflow !== 1'b0) begin n_fail++; $display("FAIL nest_empty empty=%b unf=%b exp 1/0", ras_empty, ras_underflow); end
    drive(0, 0, 32'h0, 0, 1); exp_q.push_back(cur + 32'h4); tick();
    e = exp_q.pop_front();
    n_run++; if (pc !== e || ras_underflow !== 1'b1) begin n_fail++; $display("FAIL nest_unf pc=%h unf=%b exp %h/1", pc, ras_underflow, e); end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    held = pc;
    drive(1, 1, 32'h40, 0, 0); exp_q.push_back(held);
    #1;
    n_run++; if (pc_next !== held) begin n_fail++; $display("FAIL stall_next got=%h exp=%h", pc_next, held); end
    tick();
    e = exp_q.pop_front();
    n_run++; if (pc !== e) begin n_fail++; $display("FAIL stall_hold got=%h exp=%h", pc, e); end
    drive(0, 1, 32'h40, 0, 0); exp_q.push_back(32'h40); tick();
    e = exp_q.pop_front();
    n_run++; if (pc !== e) begin n_fail++; $display("FAIL stall_reissue got=%h exp=%h", pc, e); end
  endtask

  task automatic test_misalign();
    logic [31:0] tg [4];
    logic        rv [4];
    logic [31:0] ex [4];
    logic        mis [4];
    tg  = '{32'h203, 32'h0, 32'hFFFF_FFFC, 32'h0};
    rv  = '{1'b1, 1'b0, 1'b1, 1'b0};
    ex  = '{32'h200, 32'h204, 32'hFFFF_FFFC, 32'h0};
    mis = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(0, rv[i], tg[i], 0, 0); exp_q.push_back(ex[i]); tick();
      e = exp_q.pop_front();
      n_run++; if (pc !== e) begin n_fail++; $display("FAIL mis_pc%0d got=%h exp=%h", i, pc, e); end
      n_run++; if (misalign_err !== mis[i]) begin n_fail++; $display("FAIL mis_err%0d got=%b exp=%b", i, misalign_err, mis[i]); end
    end
  endtask

  task automatic test_ret_priority();
    logic        rv [6];
    logic [31:0] tg [6];
    logic        c  [6];
    logic        r  [6];
    logic [31:0] ex [6];
    // redirect 0x500; call 0x800 (link 0x504); ret+redirect; call 0x900; tail return; ret
    rv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tg = '{32'h500, 32'h800, 32'h300, 32'h900, 32'h0, 32'h0};
    c  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    r  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    ex = '{32'h500, 32'h800, 32'h504, 32'h900, 32'h508, 32'h904};
    for (int i = 0; i < 6; i++) begin
      drive(0, rv[i], tg[i], c[i], r[i]); exp_q.push_back(ex[i]); tick();
      e = exp_q.pop_front();
      n_run++; if (pc !== e) begin n_fail++; $display("FAIL prio_pc%0d got=%h exp=%h", i, pc, e); end
      if (i == 4) begin
        n_run++; if (ras_empty !== 1'b0) begin n_fail++; $display("FAIL tail_count empty=%b exp=0", ras_empty); end
      end
    end
    n_run++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL prio_empty got=%b exp=1", ras_empty); end
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 32'h600, 1, 0); exp_q.push_back(32'h600); tick();
    e = exp_q.pop_front();
    n_run++; if (pc !== e || ras_empty !== 1'b0) begin n_fail++; $display("FAIL rm_call pc=%h empty=%b exp %h/0", pc, ras_empty, e); end
    reset = 1'b1;
    drive(1, 1, 32'h700, 1, 0); exp_q.push_back(32'h0); tick();
    e = exp_q.pop_front();
    n_run++; if (pc !== e || pc_valid !== 1'b0) begin n_fail++; $display("FAIL rm_pc pc=%h valid=%b exp %h/0", pc, pc_valid, e); end
    n_run++; if ({ras_empty, ras_overflow, ras_underflow} !== 3'b100) begin n_fail++; $display("FAIL rm_ras got=%b exp=100", {ras_empty, ras_overflow, ras_underflow}); end
    reset = 1'b0;
    drive(0, 0, 32'h0, 0, 1); exp_q.push_back(32'h4); tick();
    e = exp_q.pop_front();
    n_run++; if (pc !== e || ras_underflow !== 1'b1) begin n_fail++; $display("FAIL rm_discard pc=%h unf=%b exp %h/1", pc, ras_underflow, e); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive(0, 0, 32'h0, 0, 0);
    test_reset();
    test_call_ret();
    test_nested();
    test_stall();
    test_misalign();
    test_ret_priority();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the KGP-RISC fetch stage. Holds the current fetch address, advances it sequentially, and accepts stall, branch/jump redirect, call (push link) and return (pop link) requests through an internal circular return-address stack (RAS). Drives the instruction-memory address and the link value consumed by the register-file write path.

## Interface
- ADDR_W, 32: PC width in bits.
- INCR, 4: sequential increment in bytes; power of two.
- RESET_VECTOR, 32'h0: PC value loaded on reset; must be INCR-aligned.
- RAS_DEPTH, 4: return-address stack entries; power of two, ≥2.

- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold PC and RAS; all other requests ignored this cycle.
- redirect_valid  in  1  branch/jump taken; load redirect_target.
- redirect_target  in  ADDR_W  redirect address.
- call  in  1  with redirect_valid: push pc+INCR, jump to redirect_target.
- ret  in  1  pop RAS, jump to popped address.
- pc  out  ADDR_W  registered current fetch address.
- pc_valid  out  1  low during reset cycle, high from first cycle after.
- pc_next  out  ADDR_W  combinational address pc will take at next edge.
- link_addr  out  ADDR_W  combinational pc+INCR (link value for jal).
- ras_empty  out  1  RAS holds no entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_overflow  out  1  sticky: push occurred while full.
- ras_underflow  out  1  sticky: pop occurred while empty.
- misalign_err  out  1  one-cycle pulse: accepted redirect target not INCR-aligned.

## Operation
- Next-PC priority per cycle: reset > stall > ret > redirect_valid > sequential.
- reset: pc←RESET_VECTOR, RAS count←0, pointers←0, sticky flags←0, pc_valid←0, misalign_err←0.
- stall: pc, RAS, flags unchanged; misalign_err←0.
- ret (RAS non-empty): pc←top entry; count−1. ret with empty RAS: pc←pc+INCR, ras_underflow←1, RAS unchanged.
- ret with call asserted (tail return): pop then push link_addr into same slot; count unchanged; pc←popped value. Empty RAS: sequential, underflow set, link_addr pushed (count 1).
- redirect_valid without ret: pc←redirect_target with low log2(INCR) bits forced to 0; misalign_err←1 for one cycle if those bits were nonzero.
- call without redirect_valid and without ret: ignored (no push).
- redirect_valid & call: push link_addr, then jump. Push when full: overwrite oldest (circular), count stays RAS_DEPTH, ras_overflow←1.
- Sequential: pc←pc+INCR, modulo 2^ADDR_W (wraps to 0, no flag).
- ret has priority over a simultaneous redirect_valid; redirect_target ignored.

## Timing
- pc is registered: request sampled at edge N is visible on pc after edge N; pc_next/link_addr reflect it combinationally during cycle N.
- Reset cycle: pc=RESET_VECTOR, pc_valid=0, ras_empty=1, ras_full=0, all flags 0. First cycle after reset released: pc_valid=1, pc=RESET_VECTOR.
- Reset asserted mid-stall or mid-call: reset wins; RAS contents discarded.
- RAS flags (empty/full) are registered from count; sticky flags clear only on reset.
- Zero-cycle latency from push to pop: a ret in the cycle after a call returns the just-pushed address.

## Structure
- Package pc_pkg: default ADDR_W, INCR, RESET_VECTOR, RAS_DEPTH constants; next-PC source enum {SRC_HOLD, SRC_RET, SRC_REDIRECT, SRC_SEQ}.
- Sub-module return_addr_stack: circular buffer with top pointer, count, push/pop/replace, full/empty, overflow/underflow outputs.
- pc_unit: priority mux, alignment check, PC register, flags.

## Test plan
- Reset held 3 cycles, release, no requests -> pc = 0, 4, 8, 12 on successive cycles; pc_valid rises on first post-reset cycle.
- pc=0x100, redirect_valid+call to 0x200, next cycle ret -> pc=0x200 then 0x104; ras_empty=1 afterwards.
- Five nested calls (targets 0x1000..0x5000) with RAS_DEPTH=4 -> ras_overflow=1; four rets return to the four most recent links; fifth ret: sequential, ras_underflow=1.
- stall asserted with redirect_valid to 0x40 -> pc unchanged that cycle; after stall drops and redirect reissued -> pc=0x40.
- redirect_target 0x203 -> pc=0x200, misalign_err pulses one cycle; pc=0xFFFFFFFC sequential -> pc=0x0.
- ret and redirect_valid to 0x300 simultaneously with RAS top 0x504 -> pc=0x504.
